ov7670_stream_gen: RTL

//   Transmit side of the OV7670 parallel pixel interface; drives vsync/href/d as the sensor does.

---
 rtl/ov7670_stream_gen.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ov7670_stream_gen.sv
// OV7670-style parallel pixel source: vsync/href/d framing with RGB565 pixels sent high byte first.
// Define OV7670_STREAM_GEN_TEST_PATTERN_EN to replace the pixel input with an {x, y} test pattern.
module ov7670_stream_gen #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int H_BLANK      = 144,
    parameter int VSYNC_CYCLES = 1568,
    parameter int V_FRONT      = 10000,
    parameter int V_BACK       = 7840,
    parameter int CNT_W        = 16
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  d,
    output logic        frame_start,
    output logic        underrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_V_FRONT,
        S_LINE,
        S_H_BLANK,
        S_V_BACK
    } state_t;

    localparam logic [CNT_W-1:0] VSYNC_LAST  = CNT_W'(VSYNC_CYCLES - 1);
    localparam logic [CNT_W-1:0] VFRONT_LAST = CNT_W'(V_FRONT - 1);
    localparam logic [CNT_W-1:0] LINE_LAST   = CNT_W'(2 * H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] HBLANK_LAST = CNT_W'(H_BLANK - 1);
    localparam logic [CNT_W-1:0] VBACK_LAST  = CNT_W'(V_BACK - 1);
    localparam logic [CNT_W-1:0] LINES_LAST  = CNT_W'(V_ACTIVE - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] line_reg, line_next;
    logic             vsync_reg, href_reg, frame_start_reg, underrun_reg;
    logic [7:0]       d_reg, low_reg;
    logic             fetch;
    logic [15:0]      fetch_pix;
    logic             fetch_ok;

    always_ff @(posedge pclk) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            line_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            line_reg  <= line_next;
        end
    end

    // cnt_reg counts cycles spent in the current state; line_reg is the line being (or about to be) sent
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 1'b1;
        line_next  = line_reg;
        case (state_reg)
            S_IDLE: begin
                cnt_next = '0;
                if (enable) begin
                    state_next = S_VSYNC;
                    line_next  = '0;
                end
            end
            S_VSYNC: begin
                if (cnt_reg == VSYNC_LAST) begin
                    state_next = S_V_FRONT;
                    cnt_next   = '0;
                end
            end
            S_V_FRONT: begin
                if (cnt_reg == VFRONT_LAST) begin
                    state_next = S_LINE;
                    cnt_next   = '0;
                end
            end
            S_LINE: begin
                if (cnt_reg == LINE_LAST) begin
                    cnt_next = '0;
                    if (line_reg == LINES_LAST) begin
                        state_next = S_V_BACK;
                    end else begin
                        state_next = S_H_BLANK;
                        line_next  = line_reg + 1'b1;
                    end
                end
            end
            S_H_BLANK: begin
                if (cnt_reg == HBLANK_LAST) begin
                    state_next = S_LINE;
                    cnt_next   = '0;
                end
            end
            S_V_BACK: begin
                if (cnt_reg == VBACK_LAST) begin
                    cnt_next   = '0;
                    state_next = enable ? S_VSYNC : S_IDLE;
                    line_next  = '0;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // A pixel is fetched in the cycle before each high byte goes out
    always_comb begin
        fetch = 1'b0;
        case (state_reg)
            S_V_FRONT: fetch = (cnt_reg == VFRONT_LAST);
            S_H_BLANK: fetch = (cnt_reg == HBLANK_LAST);
            S_LINE:    fetch = cnt_reg[0] && (cnt_reg != LINE_LAST);
            default:   fetch = 1'b0;
        endcase
    end

`ifdef OV7670_STREAM_GEN_TEST_PATTERN_EN
    logic [7:0] tp_x;
    logic       unused_pix_inputs;

    // Index of the pixel about to be fetched: 0 at line start, else one past the pixel on the wire
    assign tp_x              = (state_reg == S_LINE) ? 8'(cnt_reg >> 1) + 8'd1 : 8'd0;
    assign fetch_pix         = {tp_x, line_reg[7:0]};
    assign fetch_ok          = 1'b1;
    assign pix_ready         = 1'b0;
    assign unused_pix_inputs = ^{pix_data, pix_valid};
`else
    assign fetch_pix = pix_data;
    assign fetch_ok  = pix_valid;
    assign pix_ready = fetch;
`endif

    always_ff @(posedge pclk) begin
        if (!reset) begin
            vsync_reg       <= 1'b0;
            href_reg        <= 1'b0;
            frame_start_reg <= 1'b0;
            underrun_reg    <= 1'b0;
            d_reg           <= '0;
            low_reg         <= '0;
        end else begin
            vsync_reg       <= (state_next == S_VSYNC);
            href_reg        <= (state_next == S_LINE);
            frame_start_reg <= (state_next == S_VSYNC) && (state_reg != S_VSYNC);
            if (fetch) begin
                d_reg   <= fetch_ok ? fetch_pix[15:8] : 8'h00;
                low_reg <= fetch_ok ? fetch_pix[7:0]  : 8'h00;
            end else if (state_next == S_LINE) begin
                d_reg <= low_reg;
            end else begin
                d_reg <= '0;
            end
            if (fetch && !fetch_ok) begin
                underrun_reg <= 1'b1;
            end
        end
    end

    assign vsync       = vsync_reg;
    assign href        = href_reg;
    assign d           = d_reg;
    assign frame_start = frame_start_reg;
    assign underrun    = underrun_reg;

endmodule
